// File: rtl/seq_chunk_adder_if.sv
// ---------------------------------------------------------------------------
// seq_chunk_adder_if
// Operand and result bundle for the seq_chunk_adder.
//
// Handshake: the controller raises start with the operands, sub, c_in and
// acc valid. The adder samples them only on an edge where it is idle, which
// is the cycle in which busy and done are both low. The request is not
// queued: a start seen during busy or done is dropped. done is a single-cycle
// pulse that marks s, c_out and overflow as valid. These outputs then hold
// until the next capture edge.
//
// Signals (master = controller side, slave = adder side):
//   start    : request to capture operands and begin
//   sub      : 0 = a+b+c_in, 1 = a-b
//   a, b     : operands, WIDTH bits
//   c_in     : carry-in (add mode only)
//   acc      : use current result as operand A (only with SEQ_ADDER_ACC_EN)
//   busy     : chunks being processed
//   done     : one-cycle result-valid pulse
//   s        : sum / difference, WIDTH bits
//   c_out    : carry out of MSB (sub mode: 1 = no borrow)
//   overflow : signed two's-complement overflow
// ---------------------------------------------------------------------------
interface seq_chunk_adder_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             acc;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             c_out;
  logic             overflow;

  modport master (
    output start, sub, a, b, c_in, acc,
    input  busy, done, s, c_out, overflow
  );

  modport slave (
    input  start, sub, a, b, c_in, acc,
    output busy, done, s, c_out, overflow
  );
endinterface

// File: rtl/seq_chunk_adder.sv
// ---------------------------------------------------------------------------
// seq_chunk_adder
// Multi-cycle adder/subtractor. It adds two WIDTH-bit operands CHUNK bits per
// clock and passes the carry between chunks through a register. It is meant
// for places where a full-width ripple would break timing.
//
// Parameters:
//   WIDTH : operand/result width (must be a multiple of CHUNK)
//   CHUNK : bits added per clock; NUM_CHUNKS = WIDTH/CHUNK >= 1
//
// Ports:
//   clock     : rising-edge clock
//   resetn    : asynchronous active-low reset
//   bus       : seq_chunk_adder_if.slave (operands, handshake, results)
//   dbg_state : current FSM state (0 = IDLE, 1 = RUN, 2 = DONE)
//
// Optional feature, selected by macro SEQ_ADDER_ACC_EN:
//   If defined, a capture with acc=1 takes operand A from the current s
//   register, so that results chain into a running accumulation.
//   If not defined, acc is ignored and A always comes from bus.a.
//
// Timing: the capture edge is E0. Chunks are processed on E1..E_NUM_CHUNKS.
// done is high in the cycle after E_NUM_CHUNKS. Start-to-start takes
// NUM_CHUNKS+2 cycles.
// ---------------------------------------------------------------------------
module seq_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic                 clock,
  input  logic                 resetn,
  seq_chunk_adder_if.slave     bus,
  output logic [1:0]           dbg_state
);

  localparam int NUM_CHUNKS = WIDTH / CHUNK;
  localparam int IDXW       = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_CHUNKS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;      // already inverted for subtract
  logic             carry;     // carry into the chunk processed next
  logic [IDXW-1:0]  idx;
  logic [WIDTH-1:0] s_q;
  logic             busy_q;
  logic             done_q;
  logic             c_out_q;
  logic             ovf_q;

  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK:0]   chunk_sum;
  logic             msb_carry_in;

  always_comb begin
    a_chunk   = op_a[idx*CHUNK +: CHUNK];
    b_chunk   = op_b[idx*CHUNK +: CHUNK];
    chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry};
    // The carry into the top bit of the chunk is recovered from that bit's
    // sum: sum = a ^ b ^ cin. The result is only meaningful on the last chunk.
    msb_carry_in = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ chunk_sum[CHUNK-1];
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state   <= ST_IDLE;
      op_a    <= '0;
      op_b    <= '0;
      carry   <= 1'b0;
      idx     <= '0;
      s_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          if (bus.start) begin
`ifdef SEQ_ADDER_ACC_EN
            op_a <= bus.acc ? s_q : bus.a;
`else
            op_a <= bus.a;
`endif
            op_b   <= bus.sub ? ~bus.b : bus.b;
            carry  <= bus.sub ? 1'b1 : bus.c_in;
            idx    <= '0;
            busy_q <= 1'b1;
            state  <= ST_RUN;
          end
        end

        ST_RUN: begin
          s_q[idx*CHUNK +: CHUNK] <= chunk_sum[CHUNK-1:0];
          carry                   <= chunk_sum[CHUNK];
          idx                     <= idx + IDXW'(1);
          if (idx == LAST_IDX) begin
            c_out_q <= chunk_sum[CHUNK];
            ovf_q   <= msb_carry_in ^ chunk_sum[CHUNK];
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state   <= ST_DONE;
          end
        end

        ST_DONE: begin
          // One-cycle result pulse. A start seen here is dropped.
          done_q <= 1'b0;
          state  <= ST_IDLE;
        end

        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.s        = s_q;
  assign bus.c_out    = c_out_q;
  assign bus.overflow = ovf_q;
  assign dbg_state    = state;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// ---------------------------------------------------------------------------
// tb_seq_chunk_adder
// Directed bench for seq_chunk_adder with WIDTH=16 and CHUNK=4.
// A vector table holds single operations with hand-computed results.
// Hand-written sequences cover start during busy, start held high, async
// reset in the middle of an operation, and accumulate chaining.
// ---------------------------------------------------------------------------
module tb_seq_chunk_adder;

  localparam int WIDTH = 16;
  localparam int CHUNK = 4;

  logic       clock;
  logic       resetn;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;

  seq_chunk_adder_if #(.WIDTH(WIDTH)) bus ();

  seq_chunk_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic c_in,
                       input logic sub, input logic acc, input logic start);
    bus.a     = a;
    bus.b     = b;
    bus.c_in  = c_in;
    bus.sub   = sub;
    bus.acc   = acc;
    bus.start = start;
  endtask

  // Issues one start pulse and follows the operation to done.
  //   lat     : negedges after the capture edge until done was seen (-1 if never)
  //   busy_n  : number of sampled cycles with busy high before done
  //   extra_d : done pulses in the 3 cycles after the first one
  //   hold_ok : s/c_out/overflow unchanged and busy low for those 3 cycles
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic c_in,
                        input logic sub, input logic acc,
                        output logic [15:0] rs, output logic rc, output logic ro,
                        output int lat, output int busy_n, output int extra_d,
                        output logic hold_ok);
    @(negedge clock);
    drive(a, b, c_in, sub, acc, 1'b1);
    @(posedge clock);                    // capture edge E0
    @(negedge clock);
    bus.start = 1'b0;
    // Scramble inputs: they are free to change after capture.
    bus.a    = 16'hA5A5;
    bus.b    = 16'h5A5A;
    bus.c_in = ~c_in;
    bus.sub  = ~sub;
    lat = -1; busy_n = 0; extra_d = 0; hold_ok = 1'b1;
    rs = '0; rc = 1'b0; ro = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (bus.done) begin
        lat = k;
        rs  = bus.s;
        rc  = bus.c_out;
        ro  = bus.overflow;
        break;
      end
      if (bus.busy) busy_n++;
      @(negedge clock);
    end
    if (lat >= 0) begin
      for (int k = 0; k < 3; k++) begin
        @(negedge clock);
        if (bus.done) extra_d++;
        if (bus.busy || bus.s !== rs || bus.c_out !== rc || bus.overflow !== ro)
          hold_ok = 1'b0;
      end
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        c_in;
    logic        sub;
    logic [15:0] exp_s;
    logic        exp_c;
    logic        exp_v;
  } vec_t;

  vec_t vecs[8];

  logic [15:0] rs;
  logic        rc, ro, hold_ok;
  int          lat, busy_n, extra_d;
  int          done_cnt, late_busy;
  int          done_at[$];
  logic [15:0] exp_q[$];

  initial begin
    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{16'h00FF, 16'h0F01, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0};
    vecs[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[7] = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};

    drive(16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    resetn = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_busy",  32'(bus.busy), 32'd0);
    check("reset_done",  32'(bus.done), 32'd0);
    check("reset_s",     32'(bus.s), 32'd0);
    check("reset_c_out", 32'(bus.c_out), 32'd0);
    check("reset_ovf",   32'(bus.overflow), 32'd0);
    check("reset_state", 32'(dbg_state), 32'd0);
    resetn = 1'b1;
    @(negedge clock);

    // ---------------- table-driven single operations ----------------
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].c_in, vecs[i].sub, 1'b0,
             rs, rc, ro, lat, busy_n, extra_d, hold_ok);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
      check($sformatf("vec%0d_busy_cycles", i), 32'(busy_n), 32'd4);
      check($sformatf("vec%0d_s", i), 32'(rs), 32'(vecs[i].exp_s));
      check($sformatf("vec%0d_c_out", i), 32'(rc), 32'(vecs[i].exp_c));
      check($sformatf("vec%0d_ovf", i), 32'(ro), 32'(vecs[i].exp_v));
      check($sformatf("vec%0d_single_done", i), 32'(extra_d), 32'd0);
      check($sformatf("vec%0d_hold", i), 32'(hold_ok), 32'd1);
    end

    // ---------------- start ignored while busy ----------------
    @(negedge clock);
    drive(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clock);                    // E0
    @(negedge clock);
    bus.start = 1'b0;
    @(posedge clock);                    // E1
    @(negedge clock);
    drive(16'h00FF, 16'h00FF, 1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clock);                    // E2: start must be ignored
    @(negedge clock);
    bus.start = 1'b0;
    done_cnt = 0; late_busy = 0;
    for (int k = 0; k < 14; k++) begin
      if (bus.done) begin
        done_cnt++;
        check("busy_start_s", 32'(bus.s), 32'h0002);
      end else if (done_cnt > 0 && bus.busy) begin
        late_busy++;
      end
      @(negedge clock);
    end
    check("busy_start_done_count", 32'(done_cnt), 32'd1);
    check("busy_start_no_second_op", 32'(late_busy), 32'd0);

    // ---------------- start held high: one op per NUM_CHUNKS+2 cycles ----------------
    drive(16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clock);                    // first capture
    @(negedge clock);
    done_at.delete();
    for (int k = 0; k < 20; k++) begin
      if (bus.done) done_at.push_back(k);
      @(negedge clock);
    end
    bus.start = 1'b0;
    check("held_start_done_count", 32'(done_at.size()), 32'd3);
    if (done_at.size() >= 3) begin
      check("held_start_first_latency", 32'(done_at[0]), 32'd4);
      check("held_start_period_1", 32'(done_at[1] - done_at[0]), 32'd6);
      check("held_start_period_2", 32'(done_at[2] - done_at[1]), 32'd6);
    end
    check("held_start_s", 32'(bus.s), 32'h0003);
    repeat (8) @(negedge clock);         // let the last captured op drain

    // ---------------- async reset in the middle of an operation ----------------
    drive(16'h1111, 16'h1111, 1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clock);                    // E0
    @(negedge clock);
    bus.start = 1'b0;
    @(posedge clock);                    // E1
    @(posedge clock);                    // E2
    #2;
    check("mid_partial_s_nonzero", 32'(bus.s != 16'h0), 32'd1);
    resetn = 1'b0;
    #1;                                  // no clock edge in between
    check("mid_reset_busy",  32'(bus.busy), 32'd0);
    check("mid_reset_done",  32'(bus.done), 32'd0);
    check("mid_reset_s",     32'(bus.s), 32'd0);
    check("mid_reset_c_out", 32'(bus.c_out), 32'd0);
    check("mid_reset_ovf",   32'(bus.overflow), 32'd0);
    @(posedge clock);
    @(negedge clock);
    resetn = 1'b1;
    done_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      if (bus.done || bus.busy) done_cnt++;
      @(negedge clock);
    end
    check("mid_reset_abandoned", 32'(done_cnt), 32'd0);
    run_op(16'h0003, 16'h0004, 1'b0, 1'b0, 1'b0, rs, rc, ro, lat, busy_n, extra_d, hold_ok);
    check("after_reset_s", 32'(rs), 32'h0007);
    check("after_reset_latency", 32'(lat), 32'd4);

    // ---------------- accumulate chaining ----------------
    @(negedge clock);
    resetn = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    exp_q.delete();
`ifdef SEQ_ADDER_ACC_EN
    exp_q.push_back(16'h0010); exp_q.push_back(16'h0020); exp_q.push_back(16'h0030);
`else
    exp_q.push_back(16'h0010); exp_q.push_back(16'h0010); exp_q.push_back(16'h0010);
`endif
    for (int i = 0; i < 3; i++) begin
      run_op(16'h0000, 16'h0010, 1'b0, 1'b0, 1'b1, rs, rc, ro, lat, busy_n, extra_d, hold_ok);
      check($sformatf("acc_step%0d_s", i), 32'(rs), 32'(exp_q.pop_front()));
    end

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
